// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isa_pkg
//  Description : Shared ISA definitions for the 5-stage core: opcodes,
//                instruction field positions, the NOP encoding and the
//                fetch/stall FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package isa_pkg;

    // Opcodes (instruction bits [31:27])
    localparam logic [4:0] c_OPC_R    = 5'b00000;
    localparam logic [4:0] c_OPC_ADDI = 5'b00101;
    localparam logic [4:0] c_OPC_LW   = 5'b01000;
    localparam logic [4:0] c_OPC_SW   = 5'b00111;
    localparam logic [4:0] c_OPC_JAL  = 5'b00011;
    localparam logic [4:0] c_OPC_SETX = 5'b10101;

    // Register field bit positions
    localparam int c_RD_MSB = 26;
    localparam int c_RD_LSB = 22;
    localparam int c_RS_MSB = 21;
    localparam int c_RS_LSB = 17;
    localparam int c_RT_MSB = 16;
    localparam int c_RT_LSB = 12;

    // add $0,$0,$0 -- r0 reads are excluded from hazard detection, so this
    // never stalls the front end.
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    // Fetch/stall FSM encoding
    localparam int          c_ST_W       = 1;
    localparam logic [0:0]  c_ST_RUN     = 1'b0;
    localparam logic [0:0]  c_ST_MD_WAIT = 1'b1;

endpackage : isa_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Ports       : clock  - rising-edge clock
//                reset  - asynchronous, active-low; clears the count
//                inc    - count up by one this cycle
//                count  - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fetch_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stall_unit
//  Description : Owns the PC and the F/D latch. Sequences fetch, stalls the
//                front end on data hazards and during mult/div, and squashes
//                the wrong-path instruction on taken branches.
//  Ports       : clock, reset     - clock / async active-low reset
//                imem_addr/imem_q - PC to imem, combinational instruction back
//                is_data_hazard   - hazard detector result on fd_insn
//                branch_taken/_target - redirect from X
//                md_start/md_ready    - mult/div entering X / result valid
//                fd_insn, fd_pc   - F/D latch (fd_pc is PC+1 of fd_insn)
//                dx_bubble        - D/X loads NOP this cycle
//                dx_hold          - D/X, X/M and ALU operand latches hold
//                stall_cnt, flush_cnt - saturating performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stall_unit
    import isa_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_q,
    input  logic              is_data_hazard,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              md_start,
    input  logic              md_ready,
    output logic [31:0]       fd_insn,
    output logic [ADDR_W-1:0] fd_pc,
    output logic              dx_bubble,
    output logic              dx_hold,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [31:0]       r_fd_insn;
    logic [31:0]       w_fd_insn_nxt;
    logic [ADDR_W-1:0] r_fd_pc;
    logic [ADDR_W-1:0] w_fd_pc_nxt;
    logic              w_bubble;
    logic              w_hold;
    logic              w_stall_inc;
    logic              w_flush_inc;

    // Natural wrap at 2^ADDR_W
    assign w_pc_inc = r_pc + ADDR_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_RUN;
            r_pc      <= '0;
            r_fd_insn <= NOP_INSN;
            r_fd_pc   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_fd_insn <= w_fd_insn_nxt;
            r_fd_pc   <= w_fd_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_fd_insn_nxt = r_fd_insn;
        w_fd_pc_nxt   = r_fd_pc;
        w_bubble      = 1'b0;
        w_hold        = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;

        case (r_state)
            c_ST_RUN: begin
                // md_start only picks the next state; this cycle's fetch
                // still follows the branch/hazard/advance priority below.
                if (md_start) begin
                    w_state_nxt = c_ST_MD_WAIT;
                end
                if (branch_taken) begin
                    w_pc_nxt      = branch_target;
                    w_fd_insn_nxt = NOP_INSN;
                    w_fd_pc_nxt   = '0;
                    w_bubble      = 1'b1;
                    w_flush_inc   = 1'b1;
                end else if (is_data_hazard) begin
                    w_bubble    = 1'b1;
                    w_stall_inc = 1'b1;
                end else begin
                    w_pc_nxt      = w_pc_inc;
                    w_fd_insn_nxt = imem_q;
                    w_fd_pc_nxt   = w_pc_inc;
                end
            end
            c_ST_MD_WAIT: begin
                // Everything upstream of the multiplier freezes; the
                // md_ready cycle itself is still a held (and counted) cycle.
                w_hold      = 1'b1;
                w_stall_inc = 1'b1;
                if (md_ready) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
    end

    // Gate the combinational controls with reset so they read as idle while
    // the core is held in reset regardless of what X is driving.
    assign dx_bubble = w_bubble & reset;
    assign dx_hold   = w_hold & reset;
    assign imem_addr = r_pc;
    assign fd_insn   = r_fd_insn;
    assign fd_pc     = r_fd_pc;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

endmodule : fetch_stall_unit
`default_nettype wire

// File: tb/tb_fetch_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stall_unit
//  Description : Self-checking bench for fetch_stall_unit. A small reference
//                model pushes expected register state into a scoreboard
//                queue as each cycle's stimulus is driven; entries are popped
//                and compared after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stall_unit;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_q;
    logic              is_data_hazard = 1'b0;
    logic              branch_taken   = 1'b0;
    logic [ADDR_W-1:0] branch_target  = '0;
    logic              md_start       = 1'b0;
    logic              md_ready       = 1'b0;
    logic [31:0]       fd_insn;
    logic [ADDR_W-1:0] fd_pc;
    logic              dx_bubble;
    logic              dx_hold;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    always #5 clock = ~clock;

    fetch_stall_unit #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .is_data_hazard (is_data_hazard),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .md_start       (md_start),
        .md_ready       (md_ready),
        .fd_insn        (fd_insn),
        .fd_pc          (fd_pc),
        .dx_bubble      (dx_bubble),
        .dx_hold        (dx_hold),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    // Instruction memory contents: distinct and never zero for every address
    function automatic logic [31:0] imem_f(input logic [ADDR_W-1:0] a);
        return {4'hA, 8'h3C, 8'h5C, a};
    endfunction

    assign imem_q = imem_f(imem_addr);

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       insn;
        logic [ADDR_W-1:0] fdpc;
        logic [CNT_W-1:0]  stall;
        logic [CNT_W-1:0]  flush;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [ADDR_W-1:0] m_pc;
    logic [31:0]       m_insn;
    logic [ADDR_W-1:0] m_fdpc;
    logic              m_md;
    logic [CNT_W-1:0]  m_stall;
    logic [CNT_W-1:0]  m_flush;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_insn = '0; m_fdpc = '0; m_md = 1'b0;
        m_stall = '0; m_flush = '0;
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // One clock cycle: entered just after a falling edge, leaves after the
    // following falling edge.
    task automatic cyc(input logic bt, input logic [ADDR_W-1:0] tgt,
                       input logic hz, input logic ms, input logic mr);
        exp_t e;
        logic nmd;
        branch_taken = bt; branch_target = tgt; is_data_hazard = hz;
        md_start = ms; md_ready = mr;
        #1;
        chk("dx_bubble", {31'b0, dx_bubble}, {31'b0, (!m_md && (bt || hz))});
        chk("dx_hold",   {31'b0, dx_hold},   {31'b0, m_md});
        nmd = m_md;
        if (!m_md) begin
            nmd = ms;
            if (bt) begin
                m_pc = tgt; m_insn = 32'h0; m_fdpc = '0;
                m_flush = sat_inc(m_flush);
            end else if (hz) begin
                m_stall = sat_inc(m_stall);
            end else begin
                m_insn = imem_f(m_pc);
                m_pc   = m_pc + ADDR_W'(1);
                m_fdpc = m_pc;
            end
        end else begin
            m_stall = sat_inc(m_stall);
            if (mr) nmd = 1'b0;
        end
        m_md = nmd;
        e.pc = m_pc; e.insn = m_insn; e.fdpc = m_fdpc;
        e.stall = m_stall; e.flush = m_flush;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("imem_addr", {20'b0, imem_addr}, {20'b0, e.pc});
            chk("fd_insn",   fd_insn, e.insn);
            chk("fd_pc",     {20'b0, fd_pc}, {20'b0, e.fdpc});
            chk("stall_cnt", {28'b0, stall_cnt}, {28'b0, e.stall});
            chk("flush_cnt", {28'b0, flush_cnt}, {28'b0, e.flush});
        end
        @(negedge clock);
        branch_taken = 1'b0; is_data_hazard = 1'b0;
        md_start = 1'b0; md_ready = 1'b0;
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},     {20'b0, imem_addr}, 32'd0);
        chk({tag, "_insn"},   fd_insn, 32'd0);
        chk({tag, "_fdpc"},   {20'b0, fd_pc}, 32'd0);
        chk({tag, "_stall"},  {28'b0, stall_cnt}, 32'd0);
        chk({tag, "_flush"},  {28'b0, flush_cnt}, 32'd0);
        chk({tag, "_bubble"}, {31'b0, dx_bubble}, 32'd0);
        chk({tag, "_hold"},   {31'b0, dx_hold}, 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        chk_reset_vals("reset");
        reset = 1'b1;

        // Straight-line fetch, then a 2-cycle hazard while fd_insn=B
        adv(2);
        chk("fetch_B", fd_insn, imem_f(12'd1));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("hz_pc_frozen", {20'b0, imem_addr}, 32'd2);
        adv(1);
        chk("hz_C_loads", fd_insn, imem_f(12'd2));
        chk("hz_fdpc", {20'b0, fd_pc}, 32'd3);
        chk("hz_stall2", {28'b0, stall_cnt}, 32'd2);

        // Taken branch from PC=5 to 0x040
        adv(2);
        chk("br_pc5", {20'b0, imem_addr}, 32'h005);
        cyc(1'b1, 12'h040, 1'b0, 1'b0, 1'b0);
        adv(1);
        chk("br_pc41", {20'b0, imem_addr}, 32'h041);
        chk("br_target_insn", fd_insn, imem_f(12'h040));
        chk("br_flush1", {28'b0, flush_cnt}, 32'd1);

        // Mult/div wait with branch/hazard noise; md_ready on 5th wait cycle
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 12'h123, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 12'h200, 1'b1, 1'b0, 1'b1 ^ 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 12'h300, 1'b0, 1'b0, 1'b1);
        chk("md_stall", {28'b0, stall_cnt}, 32'd7);
        chk("md_no_flush", {28'b0, flush_cnt}, 32'd1);
        adv(1);

        // PC wrap at 0xFFF
        cyc(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0);
        adv(1);
        chk("wrap_pc", {20'b0, imem_addr}, 32'h000);
        chk("wrap_fdpc", {20'b0, fd_pc}, 32'h000);
        chk("wrap_insn", fd_insn, imem_f(12'hFFF));

        // Drive stall_cnt into saturation
        for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("stall_sat", {28'b0, stall_cnt}, 32'd15);

        // Reset in the middle of MD_WAIT, away from any clock edge
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        adv(3);
        chk("restart_insn", fd_insn, imem_f(12'd2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule : tb_fetch_stall_unit
`default_nettype wire

// File: doc/fetch_stall_unit.md
# fetch_stall_unit

Owns the PC register and the F/D pipeline latch of the 5-stage core. It sequences fetch, holds the front end on load-use and RAW hazards and during multi-cycle mult/div, and squashes wrong-path instructions on taken branches. Its `fd_insn` output drives the F/D-stage hazard detector, and it consumes that detector's `is_data_hazard`. It also drives the D/X bubble select.

## Interface
- `ADDR_W`, default 12: imem word-address width.
- `CNT_W`, default 16: width of the performance counters.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `imem_addr` out ADDR_W: the current PC, presented to imem.
- `imem_q` in 32: instruction at `imem_addr`, valid in the same cycle (combinational read).
- `is_data_hazard` in 1: from the hazard detector, evaluated on the current `fd_insn`.
- `branch_taken` in 1: from X; the branch/jump in D/X resolved taken.
- `branch_target` in ADDR_W: redirect address, valid with `branch_taken`.
- `md_start` in 1: mult/div entering X this cycle.
- `md_ready` in 1: mult/div result valid; one-cycle pulse.
- `fd_insn` out 32: F/D instruction latch.
- `fd_pc` out ADDR_W: PC+1 of `fd_insn`.
- `dx_bubble` out 1: D/X latch loads NOP (32'h0) this cycle.
- `dx_hold` out 1: D/X, X/M and the ALU operand latches hold (mult/div wait).
- `stall_cnt` out CNT_W: cycles stalled by a hazard or mult/div.
- `flush_cnt` out CNT_W: taken-branch flushes.

## Operation
- NOP is 32'h0 (`add $0,$0,$0`). It never triggers the hazard detector because r0 reads are excluded there.
- FSM states:
  - RUN: normal fetch.
  - MD_WAIT: front end and X held until `md_ready`.
- Per-cycle priority in RUN:
  1. `md_start`: next state MD_WAIT. This cycle still advances or stalls per rules 2–4.
  2. `branch_taken`:
     - PC ← `branch_target`.
     - `fd_insn` ← NOP; `fd_pc` ← 0.
     - `dx_bubble`=1; `flush_cnt`++.
  3. `is_data_hazard`:
     - PC and F/D hold.
     - `dx_bubble`=1; `stall_cnt`++.
  4. Otherwise advance:
     - PC ← PC+1, modulo 2^ADDR_W; 0xFFF wraps to 0x000.
     - `fd_insn` ← `imem_q`; `fd_pc` ← PC+1 (same wrap).
- In MD_WAIT:
  - PC and F/D hold; `dx_hold`=1; `dx_bubble`=0.
  - `branch_taken` and `is_data_hazard` are ignored.
  - `stall_cnt`++ every cycle, including the `md_ready` cycle.
  - On `md_ready`: next state RUN; `dx_hold` is still 1 in that cycle.
- `md_start` and `branch_taken` in the same cycle cannot occur (a single X slot). If it does occur, the branch is applied and the FSM still enters MD_WAIT.
- `md_ready` in RUN is ignored.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset (asynchronous, active-low) forces:
  - PC=0, `fd_insn`=0, `fd_pc`=0, state RUN.
  - Both counters 0.
  - `dx_bubble`=0, `dx_hold`=0 (both combinational, derived from the reset state).
- A mid-operation reset takes effect immediately. Any pending MD_WAIT is abandoned.
- The first fetch after reset release loads imem[0] on the first rising edge.
- `dx_bubble` and `dx_hold` are combinational from state and the current-cycle inputs, with no register delay. All other outputs are registered.
- Hazard stall latency:
  - A hazard visible in cycle N freezes F/D across edge N.
  - The detector re-evaluates in N+1 against the updated downstream latches.
  - A two-deep RAW therefore produces up to 2 stall cycles.
- Flush penalty: exactly 2 wrong-path slots squashed (F/D and D/X). The target instruction appears in `fd_insn` 2 edges after `branch_taken`.
- Mult/div: the `md_start` edge enters MD_WAIT; the `md_ready` edge returns to RUN, and fetch resumes on the following edge.

## Structure
- Shared package `isa_pkg` holds:
  - Opcode constants (R=00000, ADDI=00101, LW=01000, SW=00111, JAL=00011, SETX=10101).
  - Field bit positions: rd[26:22], rs[21:17], rt[16:12].
  - `NOP_INSN`.
  - The FSM state encoding.
- Sub-module `sat_counter` (parameterised width, `clock`/`reset`, `inc`) is instantiated twice.
- Everything else is flat.

## Test plan
- Reset release with imem[0..2]=A,B,C and no hazards → `fd_insn`=A,B,C on edges 1–3; `fd_pc`=1,2,3; `stall_cnt`=0.
- `is_data_hazard` held 2 cycles while `fd_insn`=B → PC=2 and `fd_insn`=B frozen for 2 edges; `dx_bubble`=1 for both cycles; `stall_cnt`=2; C loads on the next edge.
- `branch_taken`=1 with `branch_target`=0x040 and PC=0x005 → next PC=0x041 after one advance; `fd_insn`=0 then imem[0x040]; `flush_cnt`=1; `dx_bubble`=1 for exactly 1 cycle.
- `md_start`, then `md_ready` 5 cycles later, with `branch_taken` and `is_data_hazard` toggled during the wait → `dx_hold`=1 for 5 cycles; PC and `fd_insn` unchanged throughout; no flush occurs; `stall_cnt`=5.
- PC=0xFFF advancing → next PC=0x000 and `fd_pc`=0x000. Separately, force `stall_cnt` near saturation (CNT_W=4) → it holds at 15.
- Assert reset mid-MD_WAIT → all outputs return to reset values asynchronously; after release the state is RUN and fetch restarts at 0.
